// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the debouncer family.
//   DEF_TICK_DIV / DEF_STABLE_CNT / DEF_SYNC_STAGES : default parameter values
//   width_of(n) : counter width for a modulus n, never less than one bit
package debounce_pkg;

    localparam int DEF_TICK_DIV    = 500000;
    localparam int DEF_STABLE_CNT  = 4;
    localparam int DEF_SYNC_STAGES = 2;

    // max(1, $clog2(n)) so degenerate moduli still get a legal 1-bit counter
    function automatic int width_of(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bank_tick_gen.sv
// Programmable sample-tick generator, reusable by other scanning blocks.
//   clk   : system clock
//   rst_a : synchronous active-low reset
//   en    : counts when high, freezes (tick low) when low
//   tick  : registered strobe, high for one cycle every TICK_DIV enabled cycles
module tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_a,
    input  logic en,
    output logic tick
);

    localparam int            CW   = width_of(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter; the strobe is registered in the same cycle the counter wraps
    always_ff @(posedge clk) begin
        if (!rst_a) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r  <= '0;
                tick_r <= 1'b1;
            end else begin
                cnt_r  <= cnt_r + ONE;
                tick_r <= 1'b0;
            end
        end else begin
            cnt_r  <= cnt_r;
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: one shared tick generator, per-channel synchroniser
// and stability integrator.
//   clk    : system clock
//   rst_a  : synchronous active-low reset
//   en     : tick enable; low freezes the tick counter and every integrator
//   btn_in : raw asynchronous inputs, one per channel
//   db_out : debounced level per channel
//   rise   : one-cycle pulse when db_out goes 0->1
//   fall   : one-cycle pulse when db_out goes 1->0
//   tick   : sample strobe, exported for neighbouring blocks
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   TICK_DIV    = DEF_TICK_DIV,
    parameter int   STABLE_CNT  = DEF_STABLE_CNT,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic            clk,
    input  logic            rst_a,
    input  logic            en,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] db_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    localparam int               CNT_W    = width_of(STABLE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic tick_s;
    logic sample_s;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_a (rst_a),
        .en    (en),
        .tick  (tick_s)
    );

    assign tick = tick_s;
    // Gate with en as well so a strobe already in flight cannot move a frozen integrator
    assign sample_s = tick_s & en;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_r;
        logic                   s_s;
        logic [CNT_W-1:0]       cnt_r;
        logic [CNT_W-1:0]       cnt_nxt_s;
        logic                   db_r;
        logic                   db_nxt_s;
        logic                   rise_r;
        logic                   rise_nxt_s;
        logic                   fall_r;
        logic                   fall_nxt_s;

        // Synchroniser chain; bit 0 takes the raw pin, the top bit is the clean sample
        always_ff @(posedge clk) begin
            if (!rst_a) begin
                sync_r <= {SYNC_STAGES{INIT_LEVEL}};
            end else begin
                sync_r <= {sync_r[SYNC_STAGES-2:0], btn_in[i]};
            end
        end

        assign s_s = sync_r[SYNC_STAGES-1];

        // Integrator: any agreeing sample restarts the run of differing samples
        always_comb begin
            cnt_nxt_s  = cnt_r;
            db_nxt_s   = db_r;
            rise_nxt_s = 1'b0;
            fall_nxt_s = 1'b0;
            if (sample_s) begin
                if (s_s == db_r) begin
                    cnt_nxt_s = '0;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s  = '0;
                    db_nxt_s   = s_s;
                    rise_nxt_s = s_s;
                    fall_nxt_s = ~s_s;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end

        // Integrator state and edge pulses; pulses line up with the db_out change
        always_ff @(posedge clk) begin
            if (!rst_a) begin
                cnt_r  <= '0;
                db_r   <= INIT_LEVEL;
                rise_r <= 1'b0;
                fall_r <= 1'b0;
            end else begin
                cnt_r  <= cnt_nxt_s;
                db_r   <= db_nxt_s;
                rise_r <= rise_nxt_s;
                fall_r <= fall_nxt_s;
            end
        end

        assign db_out[i] = db_r;
        assign rise[i]   = rise_r;
        assign fall[i]   = fall_r;
    end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

    logic       clk;
    logic       rst_a;
    logic       en;
    logic [1:0] btn_in;
    logic [1:0] db_out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       tick;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap_cnt = 0;

    debounce_bank #(
        .N_CH(2), .TICK_DIV(4), .STABLE_CNT(3), .SYNC_STAGES(2), .INIT_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst_a(rst_a), .en(en), .btn_in(btn_in),
        .db_out(db_out), .rise(rise), .fall(fall), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((rise & fall) != 2'b00) overlap_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next visible tick, then one more edge so the integrator result shows
    task automatic tick_sample();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tick !== 1'b1 && n < 16);
        if (tick !== 1'b1) begin
            n_checks++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
        end
        step();
    endtask

    task automatic test_reset();
        logic exp_t;
        rst_a = 1'b0; en = 1'b1; btn_in = 2'b11;
        repeat (3) step();
        n_checks++; if (db_out !== 2'b00) $display("FAIL rst_db: got %b exp 00", db_out); else n_pass++;
        n_checks++; if (rise !== 2'b00) $display("FAIL rst_rise: got %b exp 00", rise); else n_pass++;
        n_checks++; if (fall !== 2'b00) $display("FAIL rst_fall: got %b exp 00", fall); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b exp 0", tick); else n_pass++;
        btn_in = 2'b00; rst_a = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_t = ((k % 4) == 0) ? 1'b1 : 1'b0;
            n_checks++;
            if (tick !== exp_t) $display("FAIL tick_period cycle %0d: got %b exp %b", k, tick, exp_t);
            else n_pass++;
        end
        n_checks++; if (db_out !== 2'b00) $display("FAIL post_rst_db: got %b exp 00", db_out); else n_pass++;
    endtask

    task automatic test_press();
        btn_in[0] = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick_sample();
            n_checks++;
            if (db_out !== ((j == 3) ? 2'b01 : 2'b00)) $display("FAIL press_db tick %0d: got %b", j, db_out);
            else n_pass++;
        end
        n_checks++; if (rise !== 2'b01) $display("FAIL press_rise: got %b exp 01", rise); else n_pass++;
        n_checks++; if (fall !== 2'b00) $display("FAIL press_fall: got %b exp 00", fall); else n_pass++;
        step();
        n_checks++; if (rise !== 2'b00) $display("FAIL press_rise_len: got %b exp 00", rise); else n_pass++;
        n_checks++; if (db_out !== 2'b01) $display("FAIL press_hold: got %b exp 01", db_out); else n_pass++;
    endtask

    task automatic test_bounce();
        logic seq [6];
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int j = 0; j < 6; j++) begin
            btn_in[1] = seq[j];
            tick_sample();
            n_checks++;
            if (db_out !== ((j == 5) ? 2'b11 : 2'b01)) $display("FAIL bounce_db sample %0d: got %b", j + 1, db_out);
            else n_pass++;
        end
        n_checks++; if (rise !== 2'b10) $display("FAIL bounce_rise: got %b exp 10", rise); else n_pass++;
        step();
        btn_in[1] = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick_sample();
            n_checks++;
            if (db_out !== ((j == 3) ? 2'b01 : 2'b11)) $display("FAIL release_db tick %0d: got %b", j, db_out);
            else n_pass++;
        end
        n_checks++; if (fall !== 2'b10) $display("FAIL release_fall: got %b exp 10", fall); else n_pass++;
        n_checks++; if (rise !== 2'b00) $display("FAIL release_rise: got %b exp 00", rise); else n_pass++;
        step();
    endtask

    task automatic test_enable_hold();
        int bad_tick;
        int bad_db;
        bad_tick = 0; bad_db = 0;
        btn_in[0] = 1'b0;
        tick_sample();
        tick_sample();
        n_checks++; if (db_out !== 2'b01) $display("FAIL en_pre_db: got %b exp 01", db_out); else n_pass++;
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (tick !== 1'b0) bad_tick++;
            if (db_out !== 2'b01) bad_db++;
        end
        n_checks++; if (bad_tick != 0) $display("FAIL en_tick_frozen: %0d cycles with tick, exp 0", bad_tick); else n_pass++;
        n_checks++; if (bad_db != 0) $display("FAIL en_db_frozen: %0d cycles changed, exp 0", bad_db); else n_pass++;
        en = 1'b1;
        tick_sample();
        n_checks++; if (db_out !== 2'b00) $display("FAIL en_resume_db: got %b exp 00", db_out); else n_pass++;
        n_checks++; if (fall !== 2'b01) $display("FAIL en_resume_fall: got %b exp 01", fall); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        btn_in[0] = 1'b1;
        tick_sample();
        tick_sample();
        rst_a = 1'b0;
        step();
        n_checks++; if (tick !== 1'b0) $display("FAIL mid_rst_tick: got %b exp 0", tick); else n_pass++;
        n_checks++; if ({db_out, rise, fall} !== 6'b000000) $display("FAIL mid_rst_state: got db=%b rise=%b fall=%b exp 0", db_out, rise, fall); else n_pass++;
        rst_a = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick_sample();
            n_checks++;
            if (db_out !== ((j == 3) ? 2'b01 : 2'b00)) $display("FAIL mid_db tick %0d: got %b", j, db_out);
            else n_pass++;
            n_checks++;
            if (rise !== ((j == 3) ? 2'b01 : 2'b00) || fall !== 2'b00) $display("FAIL mid_pulse tick %0d: rise=%b fall=%b", j, rise, fall);
            else n_pass++;
        end
        step();
    endtask

    task automatic test_simultaneous();
        btn_in = 2'b00;
        repeat (3) tick_sample();
        n_checks++; if (db_out !== 2'b00) $display("FAIL sim_clear_db: got %b exp 00", db_out); else n_pass++;
        step();
        btn_in = 2'b11;
        tick_sample();
        tick_sample();
        n_checks++; if (db_out !== 2'b00) $display("FAIL sim_early_db: got %b exp 00", db_out); else n_pass++;
        tick_sample();
        n_checks++; if (db_out !== 2'b11) $display("FAIL sim_rise_db: got %b exp 11", db_out); else n_pass++;
        n_checks++; if (rise !== 2'b11) $display("FAIL sim_rise: got %b exp 11", rise); else n_pass++;
        step();
        n_checks++; if (rise !== 2'b00) $display("FAIL sim_rise_len: got %b exp 00", rise); else n_pass++;
        btn_in = 2'b00;
        repeat (3) tick_sample();
        n_checks++; if (db_out !== 2'b00) $display("FAIL sim_fall_db: got %b exp 00", db_out); else n_pass++;
        n_checks++; if (fall !== 2'b11) $display("FAIL sim_fall: got %b exp 11", fall); else n_pass++;
        n_checks++; if (rise !== 2'b00) $display("FAIL sim_fall_rise: got %b exp 00", rise); else n_pass++;
        step();
        n_checks++; if (fall !== 2'b00) $display("FAIL sim_fall_len: got %b exp 00", fall); else n_pass++;
        n_checks++; if (overlap_cnt != 0) $display("FAIL rise_fall_overlap: %0d cycles, exp 0", overlap_cnt); else n_pass++;
    endtask

    initial begin
        rst_a = 1'b0; en = 1'b1; btn_in = 2'b00;
        test_reset();
        test_press();
        test_bounce();
        test_enable_hold();
        test_reset_mid();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
